counter_10k: RTL and testbench

COUNTER_10K -- requirements
Module: counter_10k

---
 rtl/counter_10k_pkg.sv | 12 +
 rtl/counter_10k.sv | 64 ++++++
 tb/tb_counter_10k.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_10k_pkg.sv
// ---------------------------------------------------------------------------
// counter_10k_pkg
// Shared constants for the counter_10k period counter.
//   TERMINAL_DEFAULT : clock cycles per period (default 10000)
//   WIDTH_DEFAULT    : counter width in bits, 2**WIDTH_DEFAULT >= TERMINAL_DEFAULT
// ---------------------------------------------------------------------------
package counter_10k_pkg;

  localparam int TERMINAL_DEFAULT = 10000;
  localparam int WIDTH_DEFAULT    = 14;

endpackage : counter_10k_pkg

// File: rtl/counter_10k.sv
// ---------------------------------------------------------------------------
// counter_10k
// Free-running period counter.
// The counter advances on enabled clock edges and wraps to 0 after reaching
// TERMINAL-1. It emits a single-cycle pulse in the cycle after the wrap.
//
// Parameters
//   TERMINAL : counted cycles per period (2 .. 2**WIDTH)
//   WIDTH    : counter width in bits
//
// Ports
//   clockSource  : in  - sole clock, rising edge
//   resetCounter : in  - asynchronous active-low reset
//   enable       : in  - count enable
//   clear        : in  - synchronous restart of the period; has priority over enable
//   sigChanged   : out - registered one-cycle pulse on wrap
//   count        : out - registered current count, 0 .. TERMINAL-1
// ---------------------------------------------------------------------------
module counter_10k
  import counter_10k_pkg::*;
#(
  parameter int TERMINAL = TERMINAL_DEFAULT,
  parameter int WIDTH    = WIDTH_DEFAULT
) (
  input  logic             clockSource,
  input  logic             resetCounter,
  input  logic             enable,
  input  logic             clear,
  output logic             sigChanged,
  output logic [WIDTH-1:0] count
);

  // TERMINAL-1 always fits in WIDTH bits because TERMINAL <= 2**WIDTH.
  localparam logic [WIDTH-1:0] LAST_COUNT = WIDTH'(TERMINAL - 1);

  logic atLast;

  // Wrap is decided by an explicit terminal compare rather than by overflow,
  // so non-power-of-two periods work.
  assign atLast = (count == LAST_COUNT);

  // Registered outputs: count and pulse
  always_ff @(posedge clockSource or negedge resetCounter) begin
    if (!resetCounter) begin
      count      <= '0;
      sigChanged <= 1'b0;
    end else if (clear) begin
      // A clear landing on the terminal count also kills that period's pulse.
      count      <= '0;
      sigChanged <= 1'b0;
    end else if (enable) begin
      if (atLast) begin
        count      <= '0;
        sigChanged <= 1'b1;
      end else begin
        count      <= count + WIDTH'(1);
        sigChanged <= 1'b0;
      end
    end else begin
      sigChanged <= 1'b0;
    end
  end

endmodule : counter_10k

// File: tb/tb_counter_10k.sv
// ---------------------------------------------------------------------------
// tb_counter_10k
// Directed bench for counter_10k: default 10000-cycle instance plus a
// TERMINAL=4 / WIDTH=2 instance sharing the same clock.
// ---------------------------------------------------------------------------
module tb_counter_10k;

  logic        clk;
  logic        rstN;
  logic        enable;
  logic        clear;
  logic        sig;
  logic [13:0] count;

  logic        smallRstN;
  logic        smallEnable;
  logic        smallClear;
  logic        smallSig;
  logic [1:0]  smallCount;

  int nChecks;
  int nErrors;

  counter_10k dut (
    .clockSource (clk),
    .resetCounter(rstN),
    .enable      (enable),
    .clear       (clear),
    .sigChanged  (sig),
    .count       (count)
  );

  counter_10k #(.TERMINAL(4), .WIDTH(2)) dutSmall (
    .clockSource (clk),
    .resetCounter(smallRstN),
    .enable      (smallEnable),
    .clear       (smallClear),
    .sigChanged  (smallSig),
    .count       (smallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset for one edge and release; the next edge is cycle 1.
  task automatic doReset();
    rstN   = 1'b0;
    enable = 1'b1;
    clear  = 1'b0;
    tick();
    rstN = 1'b1;
  endtask

  task automatic test_reset();
    int firstPulse;
    rstN   = 1'b0;
    enable = 1'b1;
    clear  = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    nChecks++;
    if (count !== 14'd0 || sig !== 1'b0) begin
      nErrors++;
      $display("FAIL reset_hold: count=%0d sig=%b, expected count=0 sig=0", count, sig);
    end
    rstN = 1'b1;
    firstPulse = -1;
    for (int e = 1; e <= 10001; e++) begin
      tick();
      if (sig === 1'b1 && firstPulse < 0) firstPulse = e;
      if (e == 1) begin
        nChecks++;
        if (count !== 14'd1) begin
          nErrors++;
          $display("FAIL reset_first_edge: count=%0d, expected 1", count);
        end
      end
      if (e == 9999) begin
        nChecks++;
        if (count !== 14'd9999 || sig !== 1'b0) begin
          nErrors++;
          $display("FAIL reset_edge9999: count=%0d sig=%b, expected 9999/0", count, sig);
        end
      end
      if (e == 10000) begin
        nChecks++;
        if (count !== 14'd0 || sig !== 1'b1) begin
          nErrors++;
          $display("FAIL reset_edge10000: count=%0d sig=%b, expected 0/1", count, sig);
        end
      end
      if (e == 10001) begin
        nChecks++;
        if (count !== 14'd1 || sig !== 1'b0) begin
          nErrors++;
          $display("FAIL reset_edge10001: count=%0d sig=%b, expected 1/0", count, sig);
        end
      end
    end
    nChecks++;
    if (firstPulse != 10000) begin
      nErrors++;
      $display("FAIL reset_first_pulse: edge=%0d, expected 10000", firstPulse);
    end
  endtask

  task automatic test_free_run();
    int pulses;
    int p1, p2, p3;
    int doubles;
    logic prevSig;
    doReset();
    pulses  = 0;
    p1 = 0; p2 = 0; p3 = 0;
    doubles = 0;
    prevSig = 1'b0;
    for (int e = 1; e <= 30000; e++) begin
      tick();
      if (sig === 1'b1) begin
        pulses++;
        if (pulses == 1) p1 = e;
        if (pulses == 2) p2 = e;
        if (pulses == 3) p3 = e;
        if (prevSig === 1'b1) doubles++;
      end
      prevSig = sig;
    end
    nChecks++;
    if (pulses != 3) begin
      nErrors++;
      $display("FAIL free_run_pulses: got %0d, expected 3", pulses);
    end
    nChecks++;
    if (p1 != 10000 || p2 != 20000 || p3 != 30000) begin
      nErrors++;
      $display("FAIL free_run_spacing: edges %0d %0d %0d, expected 10000 20000 30000", p1, p2, p3);
    end
    nChecks++;
    if (doubles != 0) begin
      nErrors++;
      $display("FAIL free_run_width: %0d consecutive-high cycles, expected 0", doubles);
    end
  endtask

  task automatic test_enable();
    int holdBad;
    int firstPulse;
    doReset();
    for (int e = 1; e <= 5000; e++) tick();
    nChecks++;
    if (count !== 14'd5000) begin
      nErrors++;
      $display("FAIL enable_reach5000: count=%0d, expected 5000", count);
    end
    enable  = 1'b0;
    holdBad = 0;
    for (int e = 1; e <= 200; e++) begin
      tick();
      if (count !== 14'd5000 || sig !== 1'b0) holdBad++;
    end
    nChecks++;
    if (holdBad != 0) begin
      nErrors++;
      $display("FAIL enable_hold: %0d bad cycles, count=%0d, expected 0 bad at 5000", holdBad, count);
    end
    enable     = 1'b1;
    firstPulse = -1;
    for (int e = 1; e <= 5001; e++) begin
      tick();
      if (sig === 1'b1 && firstPulse < 0) firstPulse = e;
    end
    nChecks++;
    if (firstPulse != 5000) begin
      nErrors++;
      $display("FAIL enable_resume_pulse: edge=%0d, expected 5000", firstPulse);
    end
  endtask

  task automatic test_clear_terminal();
    int firstPulse;
    doReset();
    for (int e = 1; e <= 9999; e++) tick();
    nChecks++;
    if (count !== 14'd9999) begin
      nErrors++;
      $display("FAIL clear_reach9999: count=%0d, expected 9999", count);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    nChecks++;
    if (count !== 14'd0 || sig !== 1'b0) begin
      nErrors++;
      $display("FAIL clear_suppress: count=%0d sig=%b, expected 0/0", count, sig);
    end
    firstPulse = -1;
    for (int e = 1; e <= 10001; e++) begin
      tick();
      if (sig === 1'b1 && firstPulse < 0) firstPulse = e;
    end
    nChecks++;
    if (firstPulse != 10000) begin
      nErrors++;
      $display("FAIL clear_next_pulse: edge=%0d, expected 10000", firstPulse);
    end
  endtask

  task automatic test_async_reset();
    int firstPulse;
    doReset();
    for (int e = 1; e <= 7000; e++) tick();
    nChecks++;
    if (count !== 14'd7000) begin
      nErrors++;
      $display("FAIL async_reach7000: count=%0d, expected 7000", count);
    end
    // Assert reset between edges and look before the next edge arrives.
    #2;
    rstN = 1'b0;
    #1;
    nChecks++;
    if (count !== 14'd0 || sig !== 1'b0) begin
      nErrors++;
      $display("FAIL async_immediate: count=%0d sig=%b, expected 0/0", count, sig);
    end
    tick();
    rstN = 1'b1;
    firstPulse = -1;
    for (int e = 1; e <= 10001; e++) begin
      tick();
      if (sig === 1'b1 && firstPulse < 0) firstPulse = e;
    end
    nChecks++;
    if (firstPulse != 10000) begin
      nErrors++;
      $display("FAIL async_full_period: edge=%0d, expected 10000", firstPulse);
    end
  endtask

  task automatic test_small_terminal();
    logic [1:0] expCount [8];
    logic       expSig   [8];
    expCount = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    expSig   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    smallRstN   = 1'b0;
    smallEnable = 1'b1;
    smallClear  = 1'b0;
    tick();
    nChecks++;
    if (smallCount !== 2'd0 || smallSig !== 1'b0) begin
      nErrors++;
      $display("FAIL small_reset: count=%0d sig=%b, expected 0/0", smallCount, smallSig);
    end
    smallRstN = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      nChecks++;
      if (smallCount !== expCount[e] || smallSig !== expSig[e]) begin
        nErrors++;
        $display("FAIL small_seq[%0d]: count=%0d sig=%b, expected %0d/%b",
                 e + 1, smallCount, smallSig, expCount[e], expSig[e]);
      end
    end
    // Advance to 3, then clear with enable still high: pulse suppressed.
    for (int e = 0; e < 3; e++) tick();
    smallClear = 1'b1;
    tick();
    smallClear = 1'b0;
    nChecks++;
    if (smallCount !== 2'd0 || smallSig !== 1'b0) begin
      nErrors++;
      $display("FAIL small_clear: count=%0d sig=%b, expected 0/0", smallCount, smallSig);
    end
  endtask

  initial begin
    nChecks     = 0;
    nErrors     = 0;
    rstN        = 1'b0;
    enable      = 1'b0;
    clear       = 1'b0;
    smallRstN   = 1'b0;
    smallEnable = 1'b0;
    smallClear  = 1'b0;
    #1;
    test_small_terminal();
    test_reset();
    test_free_run();
    test_enable();
    test_clear_terminal();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule : tb_counter_10k
